csa_16_reg: RTL and testbench
=============================

Name: csa_16_reg

Overview:
- Registered three-operand adder for 16-bit unsigned operands x, y and z.
- Front end: bitwise 3:2 carry-save compression of x, y and z into a sum vector and a carry vector.
- Back end: a carry-propagate adder combines the two vectors into an 18-bit total.
- Used as a generic 3-input accumulation/arithmetic building block. Outputs are registered on clk.

Parameters:
- WIDTH, 16, operand width. s is WIDTH+1 bits. Only 16 is required to be verified.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- x  input  16  unsigned operand A.
- y  input  16  unsigned operand B.
- z  input  16  unsigned operand C.
- s  output  17  bits [16:0] of x+y+z.
- cout  output  1  bit [17] of x+y+z.

Behaviour:
- Arithmetic:
  - The total T = x+y+z is computed exactly in 18 bits. The maximum is 3*0xFFFF = 0x2FFFD, so nothing is lost.
  - {cout, s} = T.
- CSA stage, per bit i:
  - sv[i] = x^y^z.
  - cv[i+1] = majority(x,y,z), with cv[0] = 0.
  - sv is 16 bits; cv is 17 bits.
- CPA stage: T = sv + cv, zero-extended to 18 bits. The implementation is a ripple or any equivalent adder; the only requirement is the numeric result.
- Timing, default build (macro undefined):
  - Single register stage; latency 1 cycle.
  - Inputs sampled at rising edge N appear on {cout,s} immediately after edge N.
  - One new result every cycle; no handshake and no stall.
- Reset:
  - When rst=1 at a rising edge, s=0 and cout=0, and every internal pipeline register is cleared.
  - Reset has priority over data.
  - Reset asserted mid-stream discards all in-flight results; no partial results emerge afterwards.
  - After rst falls, the first valid result reflects the inputs sampled at the first edge with rst=0. It appears after the configured latency.
  - Until then, outputs stay 0.
- Inputs held constant produce a constant output.
- No X propagation from reset state: all registers have defined reset values.
- Wrap-around: none. The full 18-bit result is always represented.

Optional Feature:
- Macro: CSA16_PIPE2_EN.
- Defined:
  - Two-stage pipeline.
  - Stage 1 registers sv and cv on the clock edge.
  - Stage 2 registers the CPA result into {cout,s}.
  - Latency 2 cycles, throughput 1 result per cycle.
  - Reset clears both stages; outputs read 0 for 2 edges after reset release unless new results have arrived.
- Undefined:
  - The CSA and CPA are combinational between the input sample and a single output register.
  - Latency 1 cycle.
- The arithmetic result is identical in both builds; only latency differs.

Test Plan:
- Reset: rst=1 for 2 cycles with x=y=z=0x1234 -> s=0x00000, cout=0 throughout. Release rst -> first result 0x0369C appears after the configured latency.
- Simple: x=0x0001, y=0x0001, z=0x0001 -> s=0x00003, cout=0.
- Carry into bit 16: x=0xFFFF, y=0x0001, z=0x0001 -> s=0x10001, cout=0.
- Mixed and back-to-back:
  - Apply x=0xAAAA, y=0x5555, z=0xFFFF and x=0x1234, y=0x5678, z=0x9ABC on consecutive cycles.
  - Required: s=0x1FFFE, cout=0, then s=0x10368, cout=0, on consecutive cycles at the configured latency.
- Maximum: x=y=z=0xFFFF -> s=0x0FFFD, cout=1.
- Mid-stream reset: stream random vectors, assert rst for 1 cycle -> outputs 0 on the next edge, no stale result afterwards. Run 10k random vectors against the reference model {cout,s}=x+y+z in both builds.

Source files
------------

// File: rtl/csa_16_reg.sv
// Registered three-operand adder: 3:2 carry-save compression followed by a carry-propagate add.
// Define CSA16_PIPE2_EN to register the carry-save vectors as well (two-cycle latency).
module csa_16_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH:0]   s,
   output logic             cout
);

   logic [WIDTH-1:0] sv;
   logic [WIDTH:0]   cv;
   logic [WIDTH-1:0] sv_c;
   logic [WIDTH:0]   cv_c;
   logic [WIDTH+1:0] tot;
   logic [WIDTH+1:0] sum_q;

   // Bitwise full-adder compression; carries shift up one place.
   always_comb begin
      sv_c = x ^ y ^ z;
      cv_c = {(x & y) | (x & z) | (y & z), 1'b0};
   end

`ifdef CSA16_PIPE2_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sv <= '0;
         cv <= '0;
      end else begin
         sv <= sv_c;
         cv <= cv_c;
      end
   end
`else
   always_comb begin
      sv = sv_c;
      cv = cv_c;
   end
`endif

   always_comb begin
      tot = {2'b00, sv} + {1'b0, cv};
   end

   always_ff @(posedge clk) begin
      if (rst)
         sum_q <= '0;
      else
         sum_q <= tot;
   end

   assign s    = sum_q[WIDTH:0];
   assign cout = sum_q[WIDTH+1];

endmodule

// File: tb/tb_csa_16_reg.sv
// Randomised bench for csa_16_reg against a delayed x+y+z reference.
// Latency follows CSA16_PIPE2_EN.
module tb_csa_16_reg;
`ifdef CSA16_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic [16:0] s;
   logic        cout;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [17:0] ref_q [LAT];
   logic [17:0] hist [0:16383];

   always #5 clk = ~clk;

   csa_16_reg dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x),
      .y    (y),
      .z    (z),
      .s    (s),
      .cout (cout)
   );

   task automatic check(input string tag, input logic [17:0] got,
                        input logic [17:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%05h exp=%05h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input bit r, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c);
      rst = r;
      x = a;
      y = b;
      z = c;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < LAT; i++) ref_q[i] = '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) ref_q[i] = ref_q[i-1];
         ref_q[0] = 18'(a) + 18'(b) + 18'(c);
      end
      @(negedge clk);
      hist[cyc] = {cout, s};
      check("model", {cout, s}, ref_q[LAT-1]);
      cyc++;
   endtask

   task automatic dir(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] c,
                      input logic [17:0] e);
      int n;
      n = cyc;
      repeat (LAT) step(1'b0, a, b, c);
      check(tag, hist[n+LAT-1], e);
   endtask

   initial begin
      int n;
      logic [17:0] rel_early;
      rst = 1'b1;
      x = '0;
      y = '0;
      z = '0;
      for (int i = 0; i < LAT; i++) ref_q[i] = '0;
      @(negedge clk);

      step(1'b1, 16'h1234, 16'h1234, 16'h1234);
      step(1'b1, 16'h1234, 16'h1234, 16'h1234);
      check("rst0", hist[0], 18'h0);
      check("rst1", hist[1], 18'h0);
      repeat (LAT) step(1'b0, 16'h1234, 16'h1234, 16'h1234);
      rel_early = (LAT == 1) ? 18'h0369C : 18'h0;
      check("rel_early", hist[2], rel_early);
      check("rel_first", hist[2+LAT-1], 18'h0369C);

      dir("simple", 16'h0001, 16'h0001, 16'h0001, 18'h00003);
      dir("carry16", 16'hFFFF, 16'h0001, 16'h0001, 18'h10001);

      n = cyc;
      step(1'b0, 16'hAAAA, 16'h5555, 16'hFFFF);
      step(1'b0, 16'h1234, 16'h5678, 16'h9ABC);
      repeat (LAT - 1) step(1'b0, 16'h1234, 16'h5678, 16'h9ABC);
      check("b2b_a", hist[n+LAT-1], 18'h1FFFE);
      check("b2b_b", hist[n+LAT], 18'h10368);

      dir("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 18'h2FFFD);
      check("hold", hist[cyc-1], 18'h2FFFD);

      repeat (20) step(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
      check("midrst", hist[cyc-1], 18'h0);
      n = cyc;
      repeat (LAT) step(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      check("post_rst", hist[n+LAT-1], 18'h2FFFD);

      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 199) == 0, 16'($urandom), 16'($urandom),
              16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
